// File: rtl/memory_request_arbiter.sv
// Shared-port arbiter for instruction fetch and data load/store requests.
// Registered RAM strobes, combinational hit pulses, sticky timeout error.
module memory_request_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 64
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              halt,
  input  logic              iREN,
  input  logic [ADDR_W-1:0] iaddr,
  output logic [DATA_W-1:0] iload,
  output logic              ihit,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [DATA_W-1:0] dstore,
  output logic [DATA_W-1:0] dload,
  output logic              dhit,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [ADDR_W-1:0] ramaddr,
  output logic [DATA_W-1:0] ramstore,
  input  logic [DATA_W-1:0] ramload,
  input  logic              ram_ready,
  output logic              err
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] DATA  = 2'd1;
  localparam logic [1:0] INSTR = 2'd2;
  localparam logic [1:0] ERR   = 2'd3;

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [1:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic          r_last;

  logic          w_dreq;
  logic          w_ireq;
  logic          w_idle;
  logic          w_busy;
  logic          w_held;
  logic          w_grant_d;
  logic          w_grant_i;
  logic          w_done;
  logic          w_abort;
  logic          w_tmo;
  logic [CW-1:0] w_cnt_inc;

  assign w_dreq = dREN | dWEN;
  assign w_ireq = iREN & ~halt;
  assign w_idle = (r_state == IDLE);
  assign w_busy = (r_state == DATA) | (r_state == INSTR);

  // r_last=1 means data was served last, so a contending fetch goes next
  assign w_grant_d = w_idle & w_dreq & (~w_ireq | ~r_last);
  assign w_grant_i = w_idle & w_ireq & ~w_grant_d;

  // halt does not cancel a fetch already in flight
  assign w_held    = (r_state == DATA) ? w_dreq : iREN;
  assign w_done    = w_busy & w_held & ram_ready;
  assign w_abort   = w_busy & ~w_held;
  assign w_cnt_inc = r_cnt + 1'b1;
  assign w_tmo     = w_busy & w_held & ~ram_ready
                   & (w_cnt_inc == CW'(TIMEOUT));

  assign dhit  = w_done & (r_state == DATA);
  assign ihit  = w_done & (r_state == INSTR);
  assign dload = dhit ? ramload : '0;
  assign iload = ihit ? ramload : '0;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_last   <= 1'b0;
      ramREN   <= 1'b0;
      ramWEN   <= 1'b0;
      ramaddr  <= '0;
      ramstore <= '0;
      err      <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_grant_d) begin
            r_state  <= DATA;
            r_cnt    <= '0;
            ramaddr  <= daddr;
            ramstore <= dstore;
            ramWEN   <= dWEN;
            ramREN   <= ~dWEN;
          end else if (w_grant_i) begin
            r_state <= INSTR;
            r_cnt   <= '0;
            ramaddr <= iaddr;
            ramREN  <= 1'b1;
            ramWEN  <= 1'b0;
          end
        end
        DATA, INSTR: begin
          if (w_done || w_abort) begin
            r_state <= IDLE;
            ramREN  <= 1'b0;
            ramWEN  <= 1'b0;
            if (w_done) begin
              r_last <= (r_state == DATA);
            end
          end else if (w_tmo) begin
            r_state <= ERR;
            ramREN  <= 1'b0;
            ramWEN  <= 1'b0;
            err     <= 1'b1;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        ERR: begin
          r_state <= ERR;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_memory_request_arbiter.sv
// Scoreboard bench for memory_request_arbiter.
// Expected hits are queued at stimulus time and checked as hits appear.
module tb_memory_request_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 4;

  logic          CLK = 1'b0;
  logic          RST;
  logic          halt;
  logic          iREN;
  logic [AW-1:0] iaddr;
  logic [DW-1:0] iload;
  logic          ihit;
  logic          dREN;
  logic          dWEN;
  logic [AW-1:0] daddr;
  logic [DW-1:0] dstore;
  logic [DW-1:0] dload;
  logic          dhit;
  logic          ramREN;
  logic          ramWEN;
  logic [AW-1:0] ramaddr;
  logic [DW-1:0] ramstore;
  logic [DW-1:0] ramload;
  logic          ram_ready;
  logic          err;

  typedef struct packed {
    logic          i;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } exp_t;

  exp_t sbq[$];
  exp_t e;
  int   total = 0;
  int   bad   = 0;

  memory_request_arbiter #(
    .ADDR_W (AW),
    .DATA_W (DW),
    .TIMEOUT(TO)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .halt     (halt),
    .iREN     (iREN),
    .iaddr    (iaddr),
    .iload    (iload),
    .ihit     (ihit),
    .dREN     (dREN),
    .dWEN     (dWEN),
    .daddr    (daddr),
    .dstore   (dstore),
    .dload    (dload),
    .dhit     (dhit),
    .ramREN   (ramREN),
    .ramWEN   (ramWEN),
    .ramaddr  (ramaddr),
    .ramstore (ramstore),
    .ramload  (ramload),
    .ram_ready(ram_ready),
    .err      (err)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t mk(input logic i, input logic [AW-1:0] a,
                              input logic [DW-1:0] d);
    exp_t x;
    x.i = i;
    x.a = a;
    x.d = d;
    return x;
  endfunction

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  always @(negedge CLK) begin
    if (!RST) begin
      chk("hit_excl", 64'(ihit & dhit), 64'd0);
      if (!ihit) chk("iload_zero", 64'(iload), 64'd0);
      if (!dhit) chk("dload_zero", 64'(dload), 64'd0);
      if (ihit | dhit) begin
        if (sbq.size() == 0) begin
          chk("spurious_hit", 64'(ihit | dhit), 64'd0);
        end else begin
          e = sbq.pop_front();
          chk("hit_kind", 64'(ihit), 64'(e.i));
          chk("hit_addr", 64'(ramaddr), 64'(e.a));
          chk("hit_data", 64'(ihit ? iload : dload), 64'(e.d));
        end
      end
    end
  end

  initial begin
    RST = 1'b1; halt = 1'b0; iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
    iaddr = '0; daddr = '0; dstore = '0; ramload = '0; ram_ready = 1'b0;
    @(negedge CLK);
    chk("rst_ren", 64'(ramREN), 64'd0);
    chk("rst_wen", 64'(ramWEN), 64'd0);
    chk("rst_addr", 64'(ramaddr), 64'd0);
    chk("rst_store", 64'(ramstore), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_hits", 64'({ihit, dhit}), 64'd0);
    cyc();
    RST = 1'b0;
    cyc();

    // fetch stream, RAM always ready
    iREN = 1'b1; iaddr = 32'h40; ram_ready = 1'b1; ramload = 32'hDEADBEEF;
    repeat (3) sbq.push_back(mk(1'b1, 32'h40, 32'hDEADBEEF));
    for (int k = 0; k < 6; k++) begin
      @(negedge CLK);
      chk("t1_ren", 64'(ramREN), 64'(k % 2));
      chk("t1_ihit", 64'(ihit), 64'(k % 2));
      cyc();
    end
    iREN = 1'b0;
    cyc();
    cyc();

    // store with 3 wait cycles; address/data changes after grant ignored
    dWEN = 1'b1; dREN = 1'b1; daddr = 32'h80; dstore = 32'h1234;
    ram_ready = 1'b0; ramload = 32'h5555;
    sbq.push_back(mk(1'b0, 32'h80, 32'h5555));
    for (int k = 0; k < 6; k++) begin
      logic act;
      if (k == 2) begin daddr = 32'h99; dstore = 32'hFFFF; end
      if (k == 4) ram_ready = 1'b1;
      if (k == 5) begin ram_ready = 1'b0; dWEN = 1'b0; dREN = 1'b0; end
      @(negedge CLK);
      act = (k >= 1) && (k <= 4);
      chk("t2_wen", 64'(ramWEN), 64'(act));
      chk("t2_ren", 64'(ramREN), 64'd0);
      if (act) begin
        chk("t2_addr", 64'(ramaddr), 64'h80);
        chk("t2_store", 64'(ramstore), 64'h1234);
      end
      chk("t2_dhit", 64'(dhit), 64'(k == 4));
      cyc();
    end
    cyc();

    // contention: last grant was data, so fetch goes first, then alternate
    iREN = 1'b1; dREN = 1'b1; iaddr = 32'h40; daddr = 32'h100;
    ram_ready = 1'b1; ramload = 32'hA5A5A5A5;
    sbq.push_back(mk(1'b1, 32'h40, 32'hA5A5A5A5));
    sbq.push_back(mk(1'b0, 32'h100, 32'hA5A5A5A5));
    sbq.push_back(mk(1'b1, 32'h40, 32'hA5A5A5A5));
    sbq.push_back(mk(1'b0, 32'h100, 32'hA5A5A5A5));
    for (int k = 0; k < 8; k++) begin
      @(negedge CLK);
      chk("t3_ren", 64'(ramREN), 64'(k % 2));
      chk("t3_ihit", 64'(ihit), 64'((k == 1) || (k == 5)));
      chk("t3_dhit", 64'(dhit), 64'((k == 3) || (k == 7)));
      cyc();
    end
    iREN = 1'b0; dREN = 1'b0;
    cyc();

    // halt blocks fetches; on release the fetch wins after data
    halt = 1'b1; iREN = 1'b1; dREN = 1'b1; daddr = 32'h200;
    ram_ready = 1'b1; ramload = 32'h77;
    repeat (3) sbq.push_back(mk(1'b0, 32'h200, 32'h77));
    sbq.push_back(mk(1'b1, 32'h40, 32'h77));
    for (int k = 0; k < 8; k++) begin
      if (k == 6) halt = 1'b0;
      @(negedge CLK);
      chk("t4_ihit", 64'(ihit), 64'(k == 7));
      chk("t4_dhit", 64'(dhit), 64'((k % 2 == 1) && (k < 7)));
      cyc();
    end
    iREN = 1'b0; dREN = 1'b0;
    cyc();

    // abort in the second wait cycle
    dREN = 1'b1; daddr = 32'h300; ram_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if (k == 2) dREN = 1'b0;
      @(negedge CLK);
      chk("t5_ren", 64'(ramREN), 64'((k == 1) || (k == 2)));
      chk("t5_dhit", 64'(dhit), 64'd0);
      cyc();
    end

    // timeout into sticky error
    dREN = 1'b1; daddr = 32'h400; ram_ready = 1'b0;
    for (int k = 0; k < 9; k++) begin
      if (k == 6) begin iREN = 1'b1; ram_ready = 1'b1; end
      @(negedge CLK);
      chk("t6_ren", 64'(ramREN), 64'((k >= 1) && (k <= 4)));
      chk("t6_err", 64'(err), 64'(k >= 5));
      chk("t6_hits", 64'({ihit, dhit}), 64'd0);
      cyc();
    end
    RST = 1'b1; dREN = 1'b0; iREN = 1'b0;
    @(negedge CLK);
    chk("t6_err_rst", 64'(err), 64'd0);
    chk("t6_ren_rst", 64'(ramREN), 64'd0);
    cyc();
    RST = 1'b0;
    cyc();

    // async reset while a fetch waits on RAM
    iREN = 1'b1; iaddr = 32'h40; ram_ready = 1'b0;
    @(negedge CLK);
    chk("t7_ren0", 64'(ramREN), 64'd0);
    cyc();
    @(negedge CLK);
    chk("t7_ren1", 64'(ramREN), 64'd1);
    #2;
    RST = 1'b1;
    #1;
    chk("t7_async", 64'(ramREN), 64'd0);
    iREN = 1'b0;
    cyc();
    RST = 1'b0;
    ram_ready = 1'b1;
    cyc();
    @(negedge CLK);
    chk("t7_ren_post", 64'(ramREN), 64'd0);
    chk("t7_hits_post", 64'({ihit, dhit}), 64'd0);
    chk("sb_empty", 64'(sbq.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
